// File: rtl/lane_loader.sv
// Collects WD-bit lane words into 5-lane frames and hands each frame to a registered
// output stage. A frame may be closed early by i_din_last. A second frame can be held
// in the fill buffer while the output stage is stalled.
module lane_loader #(
  parameter int WD = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [WD-1:0] i_din,
  input  logic          i_din_valid,
  input  logic          i_din_last,
  output logic          o_din_ready,
  output logic [WD-1:0] o_out0,
  output logic [WD-1:0] o_out1,
  output logic [WD-1:0] o_out2,
  output logic [WD-1:0] o_out3,
  output logic [WD-1:0] o_out4,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_out_short,
  output logic [7:0]    o_frame_cnt
);

  typedef enum logic {S_FILL, S_PEND} state_t;

  state_t        r_state, w_state_nxt;
  logic [WD-1:0] r_fill [5];
  logic [WD-1:0] r_out  [5];
  logic [WD-1:0] w_closed [5];
  logic [2:0]    r_idx;
  logic          r_fill_short, r_out_valid, r_out_short;
  logic [7:0]    r_frame_cnt;
  logic          w_din_ready, w_acc, w_take, w_close, w_short, w_out_free;
  logic          w_load_close, w_load_fill;

  assign w_din_ready = !i_rst && (r_state == S_FILL);
  assign w_acc       = i_din_valid && w_din_ready;
  assign w_take      = !i_rst && r_out_valid && i_out_ready;
  assign w_out_free  = !r_out_valid || i_out_ready;
  assign w_close     = w_acc && ((r_idx == 3'd4) || i_din_last);
  assign w_short     = i_din_last && (r_idx != 3'd4);

  // The closing frame: accepted lanes, the current word, and zeros past it.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      if (3'(k) == r_idx)     w_closed[k] = i_din;
      else if (3'(k) < r_idx) w_closed[k] = r_fill[k];
      else                    w_closed[k] = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_close = 1'b0;
    w_load_fill  = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_close) begin
          if (w_out_free) w_load_close = 1'b1;
          else            w_state_nxt  = S_PEND;
        end
      end
      S_PEND: begin
        if (i_out_ready) begin
          w_load_fill = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the fill buffer is cleared on reset so a discarded partial frame cannot leak into later lanes.
      r_fill       <= '{default: '0};
      r_out        <= '{default: '0};
      r_idx        <= '0;
      r_fill_short <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_short  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      if (w_take) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_load_close) begin
        r_out       <= w_closed;
        r_out_short <= w_short;
        r_out_valid <= 1'b1;
        r_fill      <= '{default: '0};
        r_idx       <= '0;
      end else if (w_load_fill) begin
        r_out        <= r_fill;
        r_out_short  <= r_fill_short;
        r_out_valid  <= 1'b1;
        r_fill       <= '{default: '0};
        r_fill_short <= 1'b0;
        r_idx        <= '0;
      end else begin
        if (w_take) r_out_valid <= 1'b0;
        if (w_close) begin
          // Output stage busy: park the closed frame until it drains.
          r_fill       <= w_closed;
          r_fill_short <= w_short;
          r_idx        <= '0;
        end else if (w_acc) begin
          r_fill[r_idx] <= i_din;
          r_idx         <= r_idx + 3'd1;
        end
      end
    end
  end

  assign o_din_ready = w_din_ready;
  assign o_out0      = r_out[0];
  assign o_out1      = r_out[1];
  assign o_out2      = r_out[2];
  assign o_out3      = r_out[3];
  assign o_out4      = r_out[4];
  assign o_out_valid = r_out_valid;
  assign o_out_short = r_out_short;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_lane_loader.sv
// Bench for lane_loader: directed scenarios plus a randomized run, checked against a
// frame-level reference model built from word queues.
module tb_lane_loader;
  localparam int WD = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [WD-1:0] i_din = '0;
  logic          i_din_valid = 1'b0, i_din_last = 1'b0, i_out_ready = 1'b0;
  logic          o_din_ready, o_out_valid, o_out_short;
  logic [WD-1:0] o_out0, o_out1, o_out2, o_out3, o_out4;
  logic [7:0]    o_frame_cnt;

  always #5 clk = ~clk;

  lane_loader #(.WD(WD)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_din(i_din), .i_din_valid(i_din_valid),
    .i_din_last(i_din_last), .o_din_ready(o_din_ready),
    .o_out0(o_out0), .o_out1(o_out1), .o_out2(o_out2), .o_out3(o_out3), .o_out4(o_out4),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_short(o_out_short),
    .o_frame_cnt(o_frame_cnt)
  );

  logic [4:0][WD-1:0] dut_lanes;
  assign dut_lanes = {o_out4, o_out3, o_out2, o_out1, o_out0};

  // Reference model: words of the open frame, one parked frame, the presented frame.
  logic [WD-1:0]      m_words[$];
  bit                 m_held, m_held_short, m_valid, m_short;
  logic [4:0][WD-1:0] m_held_lanes, m_lanes;
  int                 m_cnt;
  bit                 seen_ready, exp_ready;
  int                 n_checks = 0, n_errors = 0;

  task automatic step(input logic rst, input logic [WD-1:0] din, input logic v,
                      input logic l, input logic ordy);
    logic acc, take, loaded;
    logic [4:0][WD-1:0] fr;
    @(negedge clk);
    i_rst = rst; i_din = din; i_din_valid = v; i_din_last = l; i_out_ready = ordy;
    #1;
    seen_ready = o_din_ready;
    exp_ready  = !rst && !m_held;
    acc    = v && exp_ready;
    take   = !rst && m_valid && ordy;
    loaded = 1'b0;
    @(posedge clk);
    if (rst) begin
      m_words.delete();
      m_held = 0; m_held_short = 0; m_valid = 0; m_short = 0;
      m_held_lanes = '0; m_lanes = '0; m_cnt = 0;
    end else begin
      if (m_held && ordy) begin
        m_lanes = m_held_lanes; m_short = m_held_short; m_held = 0; loaded = 1'b1;
      end else if (acc) begin
        m_words.push_back(din);
        if (m_words.size() == 5 || l) begin
          fr = '0;
          foreach (m_words[k]) fr[k] = m_words[k];
          if (!m_valid || ordy) begin
            m_lanes = fr; m_short = (m_words.size() < 5); loaded = 1'b1;
          end else begin
            m_held = 1; m_held_lanes = fr; m_held_short = (m_words.size() < 5);
          end
          m_words.delete();
        end
      end
      if (take) m_cnt = (m_cnt + 1) % 256;
      if (loaded) m_valid = 1;
      else if (take) m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, '0, 0, 0, 0);
    step(1, 4'hF, 1, 0, 1);
    n_checks++;
    if (seen_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_ready: got %b want 0", seen_ready);
    end
    n_checks++;
    if ({dut_lanes, o_out_valid, o_out_short, o_frame_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got lanes=%h v=%b s=%b cnt=%0d want all zero",
               dut_lanes, o_out_valid, o_out_short, o_frame_cnt);
    end
  endtask

  task automatic test_basic();
    step(1, '0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) step(0, 4'(i), 1, 0, 1);
    n_checks++;
    if (dut_lanes !== {4'd5, 4'd4, 4'd3, 4'd2, 4'd1} || o_out_valid !== 1'b1 || o_out_short !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_frame: got lanes=%h v=%b s=%b want 54321 v=1 s=0", dut_lanes, o_out_valid, o_out_short);
    end
    step(0, '0, 0, 0, 1);
    n_checks++;
    if (o_frame_cnt !== 8'd1 || o_out_valid !== 1'b0) begin
      n_errors++; $display("FAIL basic_cnt: got cnt=%0d v=%b want cnt=1 v=0", o_frame_cnt, o_out_valid);
    end
  endtask

  task automatic test_short();
    step(0, 4'd7, 1, 0, 0);
    step(0, 4'd8, 1, 1, 0);
    n_checks++;
    if (dut_lanes !== {4'd0, 4'd0, 4'd0, 4'd8, 4'd7} || o_out_valid !== 1'b1 || o_out_short !== 1'b1) begin
      n_errors++;
      $display("FAIL short_frame: got lanes=%h v=%b s=%b want 00087 v=1 s=1", dut_lanes, o_out_valid, o_out_short);
    end
    step(0, '0, 0, 0, 1);
  endtask

  task automatic test_pend();
    step(1, '0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(0, 4'(i), 1, 0, 0);
    step(0, 4'hA, 1, 0, 0);
    n_checks++;
    if (seen_ready !== 1'b0 || dut_lanes !== {4'd5, 4'd4, 4'd3, 4'd2, 4'd1}) begin
      n_errors++; $display("FAIL pend_hold: got ready=%b lanes=%h want ready=0 lanes=54321", seen_ready, dut_lanes);
    end
    step(0, '0, 0, 0, 1);
    n_checks++;
    if (dut_lanes !== {4'd10, 4'd9, 4'd8, 4'd7, 4'd6} || o_out_valid !== 1'b1 || o_frame_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL pend_release: got lanes=%h v=%b cnt=%0d want a9876 v=1 cnt=1", dut_lanes, o_out_valid, o_frame_cnt);
    end
    step(0, '0, 0, 0, 0);
    n_checks++;
    if (seen_ready !== 1'b1) begin
      n_errors++; $display("FAIL pend_ready: got %b want 1", seen_ready);
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    step(1, '0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      step(0, 4'($urandom), 1, 0, 1);
      if (!seen_ready) stalls++;
    end
    step(0, '0, 0, 0, 1);
    n_checks++;
    if (stalls !== 0 || o_frame_cnt !== 8'd3) begin
      n_errors++; $display("FAIL back_to_back: got stalls=%0d cnt=%0d want stalls=0 cnt=3", stalls, o_frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    step(1, '0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) step(0, 4'(i), 1, 0, 1);
    step(1, 4'd4, 1, 0, 1);
    n_checks++;
    if (seen_ready !== 1'b0) begin
      n_errors++; $display("FAIL midreset_ready: got %b want 0", seen_ready);
    end
    for (int i = 0; i < 5; i++) step(0, 4'd9, 1, 0, 1);
    n_checks++;
    if (dut_lanes !== {5{4'd9}} || o_out_short !== 1'b0) begin
      n_errors++; $display("FAIL midreset_lanes: got lanes=%h s=%b want 99999 s=0", dut_lanes, o_out_short);
    end
    step(0, '0, 0, 0, 1);
    n_checks++;
    if (o_frame_cnt !== 8'd1) begin
      n_errors++; $display("FAIL midreset_cnt: got %0d want 1", o_frame_cnt);
    end
  endtask

  task automatic test_wrap();
    step(1, '0, 0, 0, 1);
    for (int i = 0; i < 256; i++) step(0, 4'($urandom), 1, 1, 1);
    n_checks++;
    if (o_frame_cnt !== 8'd255) begin
      n_errors++; $display("FAIL wrap_255: got %0d want 255", o_frame_cnt);
    end
    step(0, '0, 0, 0, 1);
    n_checks++;
    if (o_frame_cnt !== 8'd0) begin
      n_errors++; $display("FAIL wrap_0: got %0d want 0", o_frame_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 1) == 1));
      n_checks++;
      if (seen_ready !== exp_ready) begin
        n_errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, seen_ready, exp_ready);
      end
      n_checks++;
      if ({dut_lanes, o_out_valid, o_out_short, o_frame_cnt} !== {m_lanes, m_valid, m_short, 8'(m_cnt)}) begin
        n_errors++;
        $display("FAIL rand_out[%0d]: got lanes=%h v=%b s=%b cnt=%0d want lanes=%h v=%b s=%b cnt=%0d",
                 i, dut_lanes, o_out_valid, o_out_short, o_frame_cnt, m_lanes, m_valid, m_short, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_pend();
    test_back_to_back();
    test_reset_midframe();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
